// File: rtl/debug_controller.sv
// Debugger sequencer: loads instruction memory from the byte link,
// runs or single-steps the pipeline, and reports the PC back.
module debug_controller #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD  = 8'h01,
  parameter logic [7:0]  CMD_RUN   = 8'h02,
  parameter logic [7:0]  CMD_STEP  = 8'h03,
  parameter logic [7:0]  CMD_PRST  = 8'h04
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic [31:0]       pc_in,
  input  logic              halt_detected,
  output logic              pipe_en,
  output logic              pipe_rst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, SEND_PC, PIPE_RST
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] waddr, waddr_nx;
  logic [1:0]        bcnt, bcnt_nx;
  logic [1:0]        scnt, scnt_nx;
  logic [31:0]       word, word_nx;
  logic [31:0]       shadow, shadow_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      waddr  <= '0;
      bcnt   <= '0;
      scnt   <= '0;
      word   <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nx;
      waddr  <= waddr_nx;
      bcnt   <= bcnt_nx;
      scnt   <= scnt_nx;
      word   <= word_nx;
      shadow <= shadow_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    waddr_nx  = waddr;
    bcnt_nx   = bcnt;
    scnt_nx   = scnt;
    word_nx   = word;
    shadow_nx = shadow;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_LOAD: begin
              waddr_nx = '0;
              bcnt_nx  = '0;
              state_nx = LOAD_BYTE;
            end
            CMD_RUN:  state_nx = RUN;
            CMD_STEP: state_nx = STEP;
            CMD_PRST: state_nx = PIPE_RST;
            default:  state_nx = IDLE;
          endcase
        end
      end
      LOAD_BYTE: begin
        if (rx_valid) begin
          // Little-endian assembly: the first byte ends up in [7:0]
          word_nx = {rx_data, word[31:8]};
          bcnt_nx = bcnt + 2'd1;
          if (bcnt == 2'd3)
            state_nx = LOAD_WRITE;
        end
      end
      LOAD_WRITE: begin
        waddr_nx = waddr + 1'b1;
        bcnt_nx  = '0;
        state_nx = (word == HALT_WORD) ? IDLE : LOAD_BYTE;
      end
      RUN: begin
        if (halt_detected) begin
          shadow_nx = pc_in;
          state_nx  = SEND_PC;
        end
      end
      STEP: begin
        shadow_nx = pc_in;
        state_nx  = SEND_PC;
      end
      SEND_PC: begin
        if (tx_ready) begin
          scnt_nx = scnt + 2'd1;
          if (scnt == 2'd3)
            state_nx = IDLE;
        end
      end
      PIPE_RST: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign pipe_en    = (state == RUN) || (state == STEP);
  assign pipe_rst   = (state == PIPE_RST);
  assign imem_we    = (state == LOAD_WRITE);
  assign tx_valid   = (state == SEND_PC);
  assign busy       = (state != IDLE);
  assign imem_addr  = waddr;
  assign imem_wdata = word;
  assign tx_data    = 8'(shadow >> {scnt, 3'b000});

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller with an expectation scoreboard
// for imem writes and TX bytes, plus literal spot checks.
module tb_debug_controller;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic [31:0]       pc_in;
  logic              halt_detected;
  logic              pipe_en;
  logic              pipe_rst;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;

  debug_controller #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .pc_in(pc_in), .halt_detected(halt_detected),
    .pipe_en(pipe_en), .pipe_rst(pipe_rst),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pe_cnt = 0;
  int pr_cnt = 0;
  int phase_wr = 0;
  logic [31:0] first_addr, first_data, wrap_addr, wrap_data;
  logic        stalled_prev = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] prog[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write and every accepted TX byte must be expected
  always @(negedge clk) begin
    if (!rst) begin
      if (pipe_en) pe_cnt++;
      if (pipe_rst) pr_cnt++;
      if (pipe_en) check("pipe_en_busy", 32'(busy), 32'd1);
      if (imem_we) begin
        if (phase_wr == 0) begin
          first_addr = 32'(imem_addr);
          first_data = imem_wdata;
        end
        if (phase_wr == 1024) begin
          wrap_addr = 32'(imem_addr);
          wrap_data = imem_wdata;
        end
        phase_wr++;
        if (exp_addr_q.size() == 0)
          check("unexpected_write", 32'(imem_we), 32'd0);
        else begin
          check("wr_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
          check("wr_data", imem_wdata, exp_data_q.pop_front());
        end
      end
      if (stalled_prev) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0)
          check("unexpected_tx", 32'(tx_valid), 32'd0);
        else
          check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
      end
      stalled_prev = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n && busy; i++) tick();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(pc[8*i +: 8]);
  endtask

  task automatic do_load();
    int a = 0;
    foreach (prog[i]) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(prog[i]);
      a = (a + 1) % (1 << ADDR_W);
      if (prog[i] == 32'hFFFF_FFFF) break;
    end
    phase_wr = 0;
    send_byte(8'h01);
    foreach (prog[i]) begin
      for (int j = 0; j < 4; j++) send_byte(prog[i][8*j +: 8]);
      tick();
    end
    wait_idle(20);
    check("wr_q_empty", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    pc_in = 32'h0;
    halt_detected = 1'b0;
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_pipe_en", 32'(pipe_en), 32'd0);
    check("rst_pipe_rst", 32'(pipe_rst), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    send_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      check("bad_cmd_busy", 32'(busy), 32'd0);
      tick();
    end
    check("bad_cmd_pe", 32'(pe_cnt), 32'd0);

    prog = '{32'h1234_5678, 32'hFFFF_FFFF};
    do_load();
    check("load_first_addr", first_addr, 32'd0);
    check("load_first_data", first_data, 32'h1234_5678);
    check("load_writes", 32'(phase_wr), 32'd2);

    pc_in = 32'h0000_0004;
    expect_pc(pc_in);
    pe_cnt = 0;
    send_byte(8'h03);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    check("step_tx_valid", 32'(tx_valid), 32'd1);
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_data", 32'(tx_data), 32'h00);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle(20);
    check("step_pe_cycles", 32'(pe_cnt), 32'd1);
    check("step_tx_left", 32'(exp_tx_q.size()), 32'd0);

    pc_in = 32'h0000_0050;
    expect_pc(pc_in);
    pe_cnt = 0;
    send_byte(8'h02);
    repeat (19) tick();
    halt_detected = 1'b1;
    tick();
    halt_detected = 1'b0;
    wait_idle(20);
    check("run_pe_cycles", 32'(pe_cnt), 32'd20);
    check("run_tx_left", 32'(exp_tx_q.size()), 32'd0);

    prog = {};
    for (int i = 0; i <= 1024; i++) prog.push_back(32'h0A00_0000 + i);
    prog.push_back(32'hFFFF_FFFF);
    do_load();
    check("wrap_addr", wrap_addr, 32'd0);
    check("wrap_data", wrap_data, 32'h0A00_0400);
    check("wrap_writes", 32'(phase_wr), 32'd1026);

    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(imem_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    prog = '{32'h4433_2211, 32'hFFFF_FFFF};
    do_load();
    check("reload_addr", first_addr, 32'd0);
    check("reload_data", first_data, 32'h4433_2211);

    pc_in = 32'hDEAD_BEEF;
    tx_ready = 1'b0;
    send_byte(8'h03);
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    check("abort_tx_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (6) tick();
    check("abort_tx_idle", 32'(tx_valid), 32'd0);

    pr_cnt = 0;
    pe_cnt = 0;
    send_byte(8'h04);
    wait_idle(5);
    tick();
    check("prst_cycles", 32'(pr_cnt), 32'd1);
    check("prst_pe", 32'(pe_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Sequences the pipeline (fetch stage onward) for the debugger. It gates the pipeline-wide debugger write enable (DB_WE), loads the instruction memory from a byte stream, and runs the program either continuously or one cycle at a time.
- After a run or a step it returns the current PC over the byte-serial link.
- Sits between the UART RX/TX byte interfaces and the pipeline top level.

Parameters:
- ADDR_W, 10: instruction-memory word address width.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that marks end of program during LOAD.
- CMD_LOAD, 8'h01: command byte, load program.
- CMD_RUN, 8'h02: command byte, continuous run.
- CMD_STEP, 8'h03: command byte, single step.
- CMD_PRST, 8'h04: command byte, pipeline reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  TX can accept a byte this cycle.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  8  byte to transmit.
- pc_in  in  32  current PC from the fetch stage.
- halt_detected  in  1  a HALT instruction has reached the pipeline's detection point.
- pipe_en  out  1  drives DB_WE of PC and pipeline latches; 1 = pipeline advances.
- pipe_rst  out  1  one-cycle synchronous pipeline clear.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  instruction-memory word address.
- imem_wdata  out  32  instruction-memory write data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async):
  - state = IDLE; word address, byte counter and send counter = 0.
  - Outputs tx_valid, pipe_en, pipe_rst, imem_we, busy = 0; tx_data, imem_addr, imem_wdata = 0.
- FSM states: IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, SEND_PC, PIPE_RST.
- pipe_en is a Moore decode: 1 exactly when state is RUN or STEP.
- IDLE:
  - On rx_valid, decode rx_data.
  - CMD_LOAD: clear word address and byte counter, go to LOAD_BYTE.
  - CMD_RUN: go to RUN.
  - CMD_STEP: go to STEP.
  - CMD_PRST: go to PIPE_RST.
  - Any other byte: ignored, stay in IDLE.
- LOAD_BYTE:
  - Each rx_valid shifts a byte into the word assembler, little-endian: first byte goes to [7:0], fourth to [31:24].
  - After the 4th byte, go to LOAD_WRITE.
  - Cycles without rx_valid: hold.
- LOAD_WRITE (one cycle):
  - imem_we = 1, imem_addr = current word address, imem_wdata = assembled word.
  - Next cycle: word address += 1, wrapping 2^ADDR_W-1 -> 0; byte counter = 0.
  - If the word equals HALT_WORD, go to IDLE (the HALT word itself is written). Otherwise go to LOAD_BYTE.
- RUN:
  - Stay in RUN while halt_detected = 0.
  - When halt_detected = 1 is sampled, go to SEND_PC; pipe_en falls on that edge.
- STEP:
  - Occupies exactly one cycle, so the pipeline advances exactly one edge. Then go to SEND_PC.
  - halt_detected is ignored in STEP.
- SEND_PC:
  - On entry, latch pc_in into a 32-bit shadow register.
  - Present shadow[7:0], [15:8], [23:16], [31:24] in that order, with tx_valid = 1.
  - A byte is accepted when tx_valid and tx_ready are both 1; advance to the next byte on the following cycle.
  - tx_data is held stable while tx_ready = 0.
  - After the 4th byte is accepted: tx_valid = 0, go to IDLE.
- PIPE_RST (one cycle): pipe_rst = 1, pipe_en = 0, then go to IDLE.
- rx_valid in RUN, STEP, SEND_PC or PIPE_RST is dropped. No queuing.
- rx_valid arriving in the same cycle as a state transition is handled by the current state only.
- rst asserted mid-operation (partial load word, mid-send) aborts immediately. The partial word is never written and no further TX bytes are sent.

Test Plan:
- Reset -> all outputs 0, busy = 0. Then send 0x55 -> state stays IDLE, no outputs change.
- LOAD with bytes 78 56 34 12, then FF FF FF FF -> imem_we pulses twice: addr 0 with data 0x12345678, addr 1 with data 0xFFFFFFFF. Then busy = 0.
- STEP with pc_in = 0x00000004 -> pipe_en high for exactly 1 cycle. TX sends 04 00 00 00. With tx_ready low for 3 cycles before the 2nd byte, tx_data holds 0x00 throughout the stall and no byte is duplicated.
- RUN, with halt_detected asserted 20 cycles later and pc_in = 0x00000050 -> pipe_en high for exactly 20 cycles, then TX sends 50 00 00 00.
- LOAD of 2^ADDR_W+1 non-halt words -> the last word is written at addr 0 (wrap-around).
- rst asserted after 2 load bytes, then LOAD of 4 bytes + HALT -> the first write goes to addr 0 with only the new bytes. CMD_PRST -> pipe_rst high for 1 cycle.
